mux31_rr_sel: RTL and testbench

- Round-robin select generator that sits directly upstream of the 3:1 mux (d0/d1/d2, s0/s1 -> y).
- Arbitrates three requesters, each of which owns one mux data input.
- Drives s0/s1 so the granted requester's data reaches y.
- Presents y downstream with a valid/ready handshake. A grant is held for a burst of up to BURST_LEN accepted transfers.

---
 rtl/mux31_rr_sel_if.sv | 29 ++
 rtl/mux31_rr_sel.sv | 112 +++++++++++
 tb/tb_mux31_rr_sel.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux31_rr_sel_if.sv
`default_nettype none
// ============================================================================
// Module      : mux31_rr_sel_if
// Description : Request/select/handshake bundle between the three requesters,
//               the round-robin select generator and the downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux31_rr_sel_if;
  logic [2:0] req;       // request per channel; bit i owns mux input di
  logic       ready;     // downstream accepts y this cycle
  logic       s0;        // mux select LSB
  logic       s1;        // mux select MSB
  logic [2:0] gnt;       // one-hot grant, zero when idle
  logic       valid;     // y carries a valid transfer
  logic [3:0] beat_cnt;  // accepted transfers in the current grant

  // Arbiter side: consumes requests/ready, drives select and handshake
  modport master (
    input  req, ready,
    output s0, s1, gnt, valid, beat_cnt
  );

  // Requester/consumer side
  modport slave (
    output req, ready,
    input  s0, s1, gnt, valid, beat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mux31_rr_sel.sv
`default_nettype none
// ============================================================================
// Module      : mux31_rr_sel
// Description : Round-robin select generator for a 3:1 mux. Grants one of
//               three requesters for a burst of up to BURST_LEN accepted
//               transfers and presents the mux output with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mux31_rr_sel #(
  parameter int BURST_LEN = 4,   // 1..15
  parameter int START_PTR = 2    // reset value of the last-granted pointer
) (
  input  logic            clk,
  input  logic            rst_n,
  mux31_rr_sel_if.master  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [1:0] PTR_RST   = 2'(START_PTR);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;      // last-granted channel
  logic [1:0] sel, sel_nxt;      // {s1,s0}; also the index of the granted channel
  logic [2:0] gnt, gnt_nxt;
  logic       valid, valid_nxt;
  logic [3:0] beat, beat_nxt;
  logic [1:0] cand1, cand2, win;

  // Modulo-3 increment of a channel index
  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin winner: scan ptr+1, ptr+2, ptr (mod 3); only used when req!=0
  always_comb begin
    cand1 = inc3(ptr);
    cand2 = inc3(cand1);
    if (bus.req[cand1])      win = cand1;
    else if (bus.req[cand2]) win = cand2;
    else                     win = ptr;
  end

  // State register; every output is taken straight from these flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= PTR_RST;
      sel   <= 2'd0;
      gnt   <= 3'b000;
      valid <= 1'b0;
      beat  <= 4'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      valid <= valid_nxt;
      beat  <= beat_nxt;
    end
  end

  // Next-state: arbitrate from IDLE, count beats and release from GRANT
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;      // select is held (not cleared) across IDLE
    gnt_nxt   = gnt;
    valid_nxt = valid;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        gnt_nxt   = 3'b000;
        valid_nxt = 1'b0;
        if (|bus.req) begin
          state_nxt = GRANT;
          sel_nxt   = win;
          gnt_nxt   = 3'b001 << win;
          valid_nxt = 1'b1;
          beat_nxt  = 4'd0;
        end
      end
      GRANT: begin
        // valid is always 1 here, so ready alone marks a transfer
        if (bus.ready) begin
          if ((beat == LAST_BEAT) || !bus.req[sel]) begin
            state_nxt = IDLE;
            ptr_nxt   = sel;
            gnt_nxt   = 3'b000;
            valid_nxt = 1'b0;
            beat_nxt  = 4'd0;
          end else begin
            beat_nxt  = beat + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.s0       = sel[0];
  assign bus.s1       = sel[1];
  assign bus.gnt      = gnt;
  assign bus.valid    = valid;
  assign bus.beat_cnt = beat;

endmodule
`default_nettype wire

// File: tb/tb_mux31_rr_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux31_rr_sel
// Description : Scoreboard bench for mux31_rr_sel. Two instances (BURST_LEN 4
//               and 1) share stimulus; a behavioural model predicts each
//               cycle's outputs, a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux31_rr_sel;

  typedef struct {
    logic       valid;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic [3:0] beat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mux31_rr_sel_if bus0 ();
  mux31_rr_sel_if bus1 ();

  mux31_rr_sel #(.BURST_LEN(4), .START_PTR(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux31_rr_sel #(.BURST_LEN(1), .START_PTR(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state per instance
  int   bl     [2] = '{4, 1};
  bit   m_busy [2];
  int   m_owner[2];
  int   m_beats[2];
  int   m_ptr  [2];
  int   m_sel  [2];
  exp_t q0[$];
  exp_t q1[$];

  // Grant-order recording (channel index at the start of each grant)
  int         seq0[$];
  int         seq1[$];
  logic [2:0] prev0, prev1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_owner[i] = 0; m_beats[i] = 0; m_ptr[i] = 2; m_sel[i] = 0;
    end
  endtask

  task automatic model_adv(input int i, input logic [2:0] r, input logic rd, input logic rs);
    bit found;
    int c;
    if (!rs) begin
      m_busy[i] = 1'b0; m_beats[i] = 0; m_ptr[i] = 2; m_sel[i] = 0;
    end else if (!m_busy[i]) begin
      if (r != 3'b000) begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          c = (m_ptr[i] + k) % 3;
          if (!found && r[c]) begin
            m_owner[i] = c;
            found = 1'b1;
          end
        end
        m_busy[i]  = 1'b1;
        m_beats[i] = 0;
        m_sel[i]   = m_owner[i];
      end
    end else if (rd) begin
      if (m_beats[i] == bl[i] - 1 || !r[m_owner[i]]) begin
        m_ptr[i]   = m_owner[i];
        m_busy[i]  = 1'b0;
        m_beats[i] = 0;
      end else begin
        m_beats[i]++;
      end
    end
  endtask

  function automatic exp_t mk(input int i);
    exp_t e;
    e.valid = m_busy[i];
    e.gnt   = m_busy[i] ? 3'(1 << m_owner[i]) : 3'b000;
    e.sel   = 2'(m_sel[i]);
    e.beat  = 4'(m_beats[i]);
    return e;
  endfunction

  function automatic int oh2idx(input logic [2:0] g);
    return g[0] ? 0 : (g[1] ? 1 : 2);
  endfunction

  // Drive one cycle of stimulus, push the predicted post-edge outputs,
  // then move to the following falling edge.
  task automatic step(input logic [2:0] r, input logic rd, input logic rs);
    rst_n      = rs;
    bus0.req   = r;  bus0.ready = rd;
    bus1.req   = r;  bus1.ready = rd;
    model_adv(0, r, rd, rs); q0.push_back(mk(0));
    model_adv(1, r, rd, rs); q1.push_back(mk(1));
    @(negedge clk);
    if (bus0.gnt != 3'b000 && prev0 == 3'b000) seq0.push_back(oh2idx(bus0.gnt));
    if (bus1.gnt != 3'b000 && prev1 == 3'b000) seq1.push_back(oh2idx(bus1.gnt));
    prev0 = bus0.gnt;
    prev1 = bus1.gnt;
  endtask

  task automatic do_reset();
    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
  endtask

  // Monitor: compare every cycle's DUT outputs against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("sel0_not_11", 32'({bus0.s1, bus0.s0} == 2'b11), 32'd0);
      check("gnt0_onehot0", 32'($countones(bus0.gnt) <= 1), 32'd1);
      check("sel1_not_11", 32'({bus1.s1, bus1.s0} == 2'b11), 32'd0);
      check("gnt1_onehot0", 32'($countones(bus1.gnt) <= 1), 32'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("sb0_valid", 32'(bus0.valid), 32'(e.valid));
        check("sb0_gnt",   32'(bus0.gnt),   32'(e.gnt));
        check("sb0_sel",   32'({bus0.s1, bus0.s0}), 32'(e.sel));
        check("sb0_beat",  32'(bus0.beat_cnt), 32'(e.beat));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("sb1_valid", 32'(bus1.valid), 32'(e.valid));
        check("sb1_gnt",   32'(bus1.gnt),   32'(e.gnt));
        check("sb1_sel",   32'({bus1.s1, bus1.s0}), 32'(e.sel));
        check("sb1_beat",  32'(bus1.beat_cnt), 32'(e.beat));
      end
    end
  end

  // Stimulus and directed checks
  initial begin
    logic [2:0] r;
    rst_n = 1'b0;
    bus0.req = 3'b000; bus0.ready = 1'b0;
    bus1.req = 3'b000; bus1.ready = 1'b0;
    prev0 = 3'b000; prev1 = 3'b000;
    model_reset();
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_valid", 32'(bus0.valid), 32'd0);
    check("rst_gnt",   32'(bus0.gnt),   32'd0);
    check("rst_sel",   32'({bus0.s1, bus0.s0}), 32'd0);
    check("rst_beat",  32'(bus0.beat_cnt), 32'd0);

    // Single requester: one 4-beat burst then release
    step(3'b001, 1'b1, 1'b1);
    check("t1_gnt",   32'(bus0.gnt), 32'b001);
    check("t1_sel",   32'({bus0.s1, bus0.s0}), 32'd0);
    check("t1_valid", 32'(bus0.valid), 32'd1);
    check("t1_beat0", 32'(bus0.beat_cnt), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step(3'b001, 1'b1, 1'b1);
      check("t1_beat", 32'(bus0.beat_cnt), 32'(k));
    end
    step(3'b001, 1'b1, 1'b1);
    check("t1_rel_valid", 32'(bus0.valid), 32'd0);
    check("t1_rel_gnt",   32'(bus0.gnt),   32'd0);
    step(3'b000, 1'b0, 1'b1);

    // All request: rotation 0,1,2,0
    do_reset();
    seq0.delete();
    for (int k = 0; k < 20; k++) step(3'b111, 1'b1, 1'b1);
    check("t2_ngrants", 32'(seq0.size() >= 4), 32'd1);
    if (seq0.size() >= 4) begin
      check("t2_g0", 32'(seq0[0]), 32'd0);
      check("t2_g1", 32'(seq0[1]), 32'd1);
      check("t2_g2", 32'(seq0[2]), 32'd2);
      check("t2_g3", 32'(seq0[3]), 32'd0);
    end

    // Stall with toggling requests: grant must hold
    do_reset();
    step(3'b010, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step((k % 2 == 0) ? 3'b101 : 3'b010, 1'b0, 1'b1);
      check("t3_gnt",   32'(bus0.gnt), 32'b010);
      check("t3_sel",   32'({bus0.s1, bus0.s0}), 32'd1);
      check("t3_valid", 32'(bus0.valid), 32'd1);
      check("t3_beat",  32'(bus0.beat_cnt), 32'd0);
    end
    step(3'b000, 1'b1, 1'b1);

    // Early release when the granted request drops
    do_reset();
    step(3'b100, 1'b0, 1'b1);
    check("t4_gnt2", 32'(bus0.gnt), 32'b100);
    check("t4_sel2", 32'({bus0.s1, bus0.s0}), 32'd2);
    step(3'b011, 1'b0, 1'b1);
    check("t4_hold", 32'(bus0.gnt), 32'b100);
    step(3'b011, 1'b1, 1'b1);
    check("t4_rel_valid", 32'(bus0.valid), 32'd0);
    check("t4_rel_gnt",   32'(bus0.gnt),   32'd0);
    step(3'b011, 1'b1, 1'b1);
    check("t4_next", 32'(bus0.gnt), 32'b001);
    step(3'b000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a burst
    do_reset();
    step(3'b111, 1'b1, 1'b1);
    step(3'b111, 1'b1, 1'b1);
    step(3'b111, 1'b1, 1'b1);
    check("t5_beat2", 32'(bus0.beat_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(bus0.valid), 32'd0);
    check("t5_async_gnt",   32'(bus0.gnt),   32'd0);
    check("t5_async_beat",  32'(bus0.beat_cnt), 32'd0);
    step(3'b111, 1'b1, 1'b0);
    step(3'b111, 1'b1, 1'b1);
    check("t5_after_rst", 32'(bus0.gnt), 32'b001);
    step(3'b000, 1'b0, 1'b1);

    // Single-beat bursts alternate between two requesters
    do_reset();
    seq1.delete();
    for (int k = 0; k < 8; k++) begin
      step(3'b011, 1'b1, 1'b1);
      check("t6_beat", 32'(bus1.beat_cnt), 32'd0);
    end
    check("t6_ngrants", 32'(seq1.size()), 32'd4);
    if (seq1.size() == 4) begin
      check("t6_g0", 32'(seq1[0]), 32'd0);
      check("t6_g1", 32'(seq1[1]), 32'd1);
      check("t6_g2", 32'(seq1[2]), 32'd0);
      check("t6_g3", 32'(seq1[3]), 32'd1);
    end

    // Random traffic, occasional reset
    for (int k = 0; k < 500; k++) begin
      r = 3'($urandom_range(0, 7));
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 79) != 0));
    end

    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b1);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
